// File: rtl/multi_chan_counter.sv
// multi_chan_counter: independent up/down counters with snapshot and beat-by-beat readout
module multi_chan_counter #(
  parameter int D_WIDTH = 8,
  parameter int N_CH = 4,
  parameter bit SATURATE = 1'b0,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         enable,
  input  logic [N_CH-1:0]         up_dn,
  input  logic [N_CH-1:0]         clear,
  input  logic [N_CH-1:0]         load,
  input  logic [N_CH*D_WIDTH-1:0] load_val,
  output logic [N_CH*D_WIDTH-1:0] data,
  output logic [N_CH-1:0]         wrap,
  input  logic                    snap_req,
  output logic                    busy,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [CW-1:0]           rd_ch,
  output logic [D_WIDTH-1:0]      rd_data,
  output logic                    rd_last
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [N_CH-1:0][D_WIDTH-1:0] cnt_q, cnt_d, snap_q, snap_d;
  logic [N_CH-1:0] wrap_q, wrap_d;
  logic [CW-1:0] rd_ch_q, rd_ch_d;
  logic xfer;
  // per-channel next value: clear beats load beats count; limit hit raises wrap next cycle
  always_comb begin
    cnt_d = cnt_q;
    wrap_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      wrap_d[i] = !clear[i] && !load[i] && enable[i] && (up_dn[i] ? &cnt_q[i] : ~|cnt_q[i]);
      cnt_d[i] = clear[i] ? '0 :
                 load[i] ? load_val[i*D_WIDTH +: D_WIDTH] :
                 !enable[i] || (SATURATE && wrap_d[i]) ? cnt_q[i] :
                 up_dn[i] ? cnt_q[i] + D_WIDTH'(1) : cnt_q[i] - D_WIDTH'(1);
    end
  end
  // counter and limit-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wrap_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wrap_q <= wrap_d;
    end
  end
  // readout next state: snapshot only when leaving IDLE, advance channel on each accepted beat
  always_comb begin
    xfer = (state_q == SEND) && rd_ready;
    state_d = (state_q == IDLE) ? (snap_req ? SEND : IDLE) : (xfer && rd_last ? IDLE : SEND);
    rd_ch_d = xfer ? (rd_last ? '0 : rd_ch_q + CW'(1)) : rd_ch_q;
    snap_d = (state_q == IDLE && snap_req) ? cnt_q : snap_q;
  end
  // readout state, channel pointer and snapshot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_ch_q <= '0;
      snap_q <= '0;
    end else begin
      state_q <= state_d;
      rd_ch_q <= rd_ch_d;
      snap_q <= snap_d;
    end
  end
  // outputs: readout fields are zero outside SEND
  always_comb begin
    data = cnt_q;
    wrap = wrap_q;
    busy = state_q == SEND;
    rd_valid = busy;
    rd_ch = rd_ch_q;
    rd_last = busy && rd_ch_q == CW'(N_CH - 1);
    rd_data = busy ? snap_q[rd_ch_q] : '0;
  end
endmodule
